bit_serial_subtractor: RTL and testbench



---
 rtl/bit_serial_subtractor.sv | 120 ++++++++++++
 tb/tb_bit_serial_subtractor.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bit_serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b - borrow_in, one bit per clock, LSB first.
// Optional signed-overflow flag is built only when BIT_SERIAL_SUB_OVERFLOW_EN is defined.
module bit_serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t         state;
  state_t         next_state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CW-1:0]    cnt;
  logic             br;

  logic             accept;
  logic             last_shift;
  logic             bit_d;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  assign accept     = (state == S_IDLE) && start;
  assign last_shift = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
  assign bit_d      = a_sr[0] ^ b_sr[0] ^ br;
  assign br_next    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
  assign res_next   = {bit_d, res_sr[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_SHIFT;
      S_SHIFT: if (last_shift) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state)
      S_IDLE:  busy = 1'b0;
      S_SHIFT: busy = 1'b1;
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Datapath: result register stays internal; visible outputs load only on the last shift.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
      zero       <= 1'b0;
    end else if (accept) begin
      a_sr <= a;
      b_sr <= b;
      br   <= borrow_in;
      cnt  <= '0;
    end else if (state == S_SHIFT) begin
      a_sr   <= {1'b0, a_sr[WIDTH-1:1]};
      b_sr   <= {1'b0, b_sr[WIDTH-1:1]};
      res_sr <= res_next;
      br     <= br_next;
      cnt    <= cnt + CW'(1);
      if (last_shift) begin
        diff       <= res_next;
        borrow_out <= br_next;
        zero       <= (res_next == '0);
      end
    end
  end

`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk) begin
    if (reset)           overflow <= 1'b0;
    else if (last_shift) overflow <= br ^ br_next;
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_subtractor.sv
// Directed bench for bit_serial_subtractor (WIDTH=8): vector table plus handshake/reset corner sequences.
module tb_bit_serial_subtractor;

  localparam int W = 8;
`ifdef BIT_SERIAL_SUB_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         borrow_in = 1'b0;
  logic         busy, done, borrow_out, zero, overflow;
  logic [W-1:0] diff;

  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] held_diff = '0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         bo;
    logic         z;
    logic         ov;
  } vec_t;

  vec_t vecs[8];

  bit_serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .borrow_in(borrow_in),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out),
    .zero(zero), .overflow(overflow)
  );

  // Clock and reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_start(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bin);
    a = av;
    b = bv;
    borrow_in = bin;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full operation with cycle-exact handshake checks; called with the DUT idle.
  task automatic run_op(input vec_t v, input string name);
    logic [W-1:0] e;
    exp_q.push_back(v.diff);
    drive_start(v.a, v.b, v.bin);
    for (int i = 1; i <= W; i++) begin
      chk({name, " busy_shift"}, busy, 1);
      chk({name, " done_shift"}, done, 0);
      chk({name, " diff_hold"}, diff, held_diff);
      tick();
    end
    e = exp_q.pop_front();
    chk({name, " done"}, done, 1);
    chk({name, " diff"}, diff, e);
    chk({name, " borrow_out"}, borrow_out, v.bo);
    chk({name, " zero"}, zero, v.z);
    chk({name, " overflow"}, overflow, OVF_EN ? v.ov : 1'b0);
    held_diff = e;
    tick();
    chk({name, " busy_after"}, busy, 0);
    chk({name, " done_after"}, done, 0);
    chk({name, " diff_keep"}, diff, e);
  endtask

  initial begin
    vec_t v;
    int ndone;
    bit seen;

    //          a      b      bin   diff   bo    z     ov
    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{8'h10, 8'h0F, 1'b1, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b0, 1'b1};
    vecs[4] = '{8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b0, 1'b1};
    vecs[5] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h4A, 1'b0, 1'b0, 1'b1};

    // Reset held with start high: reset must win
    a = 8'h05; b = 8'h03; start = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    start = 1'b0;
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset diff", diff, 0);
    chk("reset borrow_out", borrow_out, 0);
    chk("reset zero", zero, 0);
    chk("reset overflow", overflow, 0);
    tick();
    chk("reset_prio busy", busy, 0);

    for (int i = 0; i < 8; i++) begin
      v = vecs[i];
      run_op(v, $sformatf("vec%0d", i));
    end

    // Start during SHIFT and in DONE ignored; start in the following IDLE accepted
    ndone = 0;
    drive_start(8'h05, 8'h03, 1'b0);
    for (int cyc = 1; cyc <= W + 2; cyc++) begin
      if (cyc == 3 || cyc == W + 1) begin
        a = 8'hFF; b = 8'h00; start = 1'b1;
      end else if (cyc == W + 2) begin
        a = 8'h20; b = 8'h01; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) ndone++;
      if (cyc <= W) chk("ign busy_shift", busy, 1);
      if (cyc == W + 1) begin
        chk("ign done", done, 1);
        chk("ign diff", diff, 8'h02);
      end
      if (cyc == W + 2) chk("ign idle_after_done", busy, 0);
      tick();
    end
    start = 1'b0;
    chk("ign single_done", ndone, 1);
    chk("accept busy", busy, 1);
    seen = 1'b0;
    for (int k = 0; k < W + 5 && !seen; k++) begin
      if (done) begin
        seen = 1'b1;
        chk("accept diff", diff, 8'h1F);
        chk("accept borrow_out", borrow_out, 0);
      end else begin
        tick();
      end
    end
    chk("accept done_seen", seen, 1);
    tick();

    // Reset mid-operation aborts with no done
    drive_start(8'h05, 8'h03, 1'b0);
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort diff", diff, 0);
    chk("abort borrow_out", borrow_out, 0);
    chk("abort zero", zero, 0);
    chk("abort overflow", overflow, 0);
    ndone = 0;
    for (int k = 0; k < 20; k++) begin
      if (done || busy) ndone++;
      tick();
    end
    chk("abort quiet", ndone, 0);
    held_diff = '0;
    v = '{8'h09, 8'h04, 1'b0, 8'h05, 1'b0, 1'b0, 1'b0};
    run_op(v, "fresh");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
